// File: rtl/centroid_calc_if.sv
// Row/frame input and centroid result bundle for centroid_calc.
// The slave modport is the calculator; master is whoever feeds rows and consumes results.
interface centroid_calc_if #(
  parameter int ADDR_WIDTH  = 11,
  parameter int MDATA_WIDTH = 640,
  parameter int CNT_WIDTH   = 20
);
  logic                   iFRAME_START;
  logic                   iFRAME_END;
  logic                   iROW_VLD;
  logic [ADDR_WIDTH-1:0]  iROW_IDX;
  logic [MDATA_WIDTH-1:0] iROW_DATA;
  logic                   oBUSY;
  logic                   oRES_VLD;
  logic [ADDR_WIDTH-1:0]  oCX;
  logic [ADDR_WIDTH-1:0]  oCY;
  logic [CNT_WIDTH-1:0]   oCOUNT;
  logic                   oNOPIX;
  logic                   oOVF;

  modport master (
    output iFRAME_START, iFRAME_END, iROW_VLD, iROW_IDX, iROW_DATA,
    input  oBUSY, oRES_VLD, oCX, oCY, oCOUNT, oNOPIX, oOVF
  );

  modport slave (
    input  iFRAME_START, iFRAME_END, iROW_VLD, iROW_IDX, iROW_DATA,
    output oBUSY, oRES_VLD, oCX, oCY, oCOUNT, oNOPIX, oOVF
  );
endinterface

// File: rtl/centroid_calc.sv
// Pupil centroid: accumulates count / sum-X / sum-Y of binary rows, then divides sequentially at frame end.
// Optional build macro CENTROID_ROUND_EN selects round-to-nearest quotients instead of truncation.
module centroid_calc #(
  parameter int ADDR_WIDTH  = 11,
  parameter int MDATA_WIDTH = 640,
  parameter int SCAN_W      = 32,
  parameter int CNT_WIDTH   = 20,
  parameter int SUM_WIDTH   = 32
) (
  input  logic            CCLK,
  input  logic            RST,
  centroid_calc_if.slave  io_bus
);

  localparam int N_CHUNK = MDATA_WIDTH / SCAN_W;
  localparam int CHUNK_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int BIT_W   = $clog2(SUM_WIDTH);
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N_CHUNK - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(SUM_WIDTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] DIV_X = 3'd2;
  localparam logic [2:0] DIV_Y = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0]             r_state;
  logic [MDATA_WIDTH-1:0] r_row;
  logic [ADDR_WIDTH-1:0]  r_row_idx;
  logic [CHUNK_W-1:0]     r_chunk;
  logic [SUM_WIDTH-1:0]   r_col_base;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [SUM_WIDTH-1:0]   r_sumx;
  logic [SUM_WIDTH-1:0]   r_sumy;
  logic                   r_pend;
  logic [SUM_WIDTH-1:0]   r_dvs;
  logic [SUM_WIDTH-1:0]   r_quo;
  logic [SUM_WIDTH-1:0]   r_rem;
  logic [SUM_WIDTH-1:0]   r_dvd_y;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [ADDR_WIDTH-1:0]  r_qx;
  logic                   r_zero;
  logic [CNT_WIDTH-1:0]   r_cnt_hold;
  logic [ADDR_WIDTH-1:0]  r_cx;
  logic [ADDR_WIDTH-1:0]  r_cy;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_nopix;
  logic                   r_res_vld;
  logic                   r_ovf;

  logic                   w_scan;
  logic                   w_clear_frame;
  logic                   w_go_div;
  logic [SUM_WIDTH-1:0]   w_pop;
  logic [SUM_WIDTH-1:0]   w_colsum;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic [SUM_WIDTH-1:0]   w_sumx_nxt;
  logic [SUM_WIDTH-1:0]   w_sumy_nxt;
  logic [SUM_WIDTH-1:0]   w_round;
  logic [SUM_WIDTH:0]     w_shift;
  logic [SUM_WIDTH:0]     w_diff;
  logic                   w_fits;
  logic [SUM_WIDTH-1:0]   w_rem_nxt;
  logic [SUM_WIDTH-1:0]   w_quo_nxt;

  // The low SCAN_W bits of r_row are always the current chunk; the row shifts right each SCAN cycle.
  // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    w_pop    = '0;
    w_colsum = '0;
    for (int j = 0; j < SCAN_W; j++) begin
      if (r_row[j]) begin
        w_pop    = w_pop + SUM_WIDTH'(1);
        w_colsum = w_colsum + r_col_base + SUM_WIDTH'(j);
      end
    end
  end

  assign w_scan     = (r_state == SCAN);
  assign w_cnt_nxt  = w_scan ? r_cnt + CNT_WIDTH'(w_pop) : r_cnt;
  assign w_sumx_nxt = w_scan ? r_sumx + w_colsum : r_sumx;
  assign w_sumy_nxt = w_scan ? r_sumy + SUM_WIDTH'(r_row_idx) * w_pop : r_sumy;

`ifdef CENTROID_ROUND_EN
  assign w_round = SUM_WIDTH'(w_cnt_nxt >> 1);
`else
  assign w_round = '0;
`endif

  assign w_clear_frame = io_bus.iFRAME_START && (r_state == IDLE || r_state == SCAN);

  // A frame end seen with a row (or during a scan) waits for the scan's last chunk before dividing.
  assign w_go_div =
      (r_state == IDLE && io_bus.iFRAME_END && !io_bus.iFRAME_START && !io_bus.iROW_VLD) ||
      (w_scan && !io_bus.iFRAME_START && r_chunk == LAST_CHUNK && (r_pend || io_bus.iFRAME_END));

  // Restoring divider step: r_quo holds the dividend bits still to consume and collects quotient bits.
  assign w_shift   = {r_rem, r_quo[SUM_WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_fits    = ~w_diff[SUM_WIDTH];
  assign w_rem_nxt = w_fits ? w_diff[SUM_WIDTH-1:0] : w_shift[SUM_WIDTH-1:0];
  assign w_quo_nxt = {r_quo[SUM_WIDTH-2:0], w_fits};

  // NOTE: sequential state uses non-blocking assignments only; later assignments in this block win.
  always_ff @(posedge CCLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_row_idx  <= '0;
      r_chunk    <= '0;
      r_col_base <= '0;
      r_cnt      <= '0;
      r_sumx     <= '0;
      r_sumy     <= '0;
      r_pend     <= 1'b0;
      r_dvs      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvd_y    <= '0;
      r_bit_cnt  <= '0;
      r_qx       <= '0;
      r_zero     <= 1'b0;
      r_cnt_hold <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_count    <= '0;
      r_nopix    <= 1'b0;
      r_res_vld  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_res_vld <= 1'b0;

      if (io_bus.iFRAME_START) r_ovf <= 1'b0;
      if (io_bus.iROW_VLD && r_state != IDLE) r_ovf <= 1'b1;

      if (w_clear_frame || w_go_div) begin
        r_cnt  <= '0;
        r_sumx <= '0;
        r_sumy <= '0;
      end else if (w_scan) begin
        r_cnt  <= w_cnt_nxt;
        r_sumx <= w_sumx_nxt;
        r_sumy <= w_sumy_nxt;
      end

      case (r_state)
        IDLE: begin
          if (io_bus.iROW_VLD) begin
            r_row      <= io_bus.iROW_DATA;
            r_row_idx  <= io_bus.iROW_IDX;
            r_chunk    <= '0;
            r_col_base <= '0;
            r_pend     <= io_bus.iFRAME_END && !io_bus.iFRAME_START;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (io_bus.iFRAME_START) begin
            r_pend  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_row      <= r_row >> SCAN_W;
            r_chunk    <= r_chunk + CHUNK_W'(1);
            r_col_base <= r_col_base + SUM_WIDTH'(SCAN_W);
            if (io_bus.iFRAME_END) r_pend <= 1'b1;
            if (r_chunk == LAST_CHUNK) r_state <= IDLE;
          end
        end
        DIV_X: begin
          r_rem     <= w_rem_nxt;
          r_quo     <= w_quo_nxt;
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == LAST_BIT) begin
            r_qx      <= w_quo_nxt[ADDR_WIDTH-1:0];
            r_quo     <= r_dvd_y;
            r_rem     <= '0;
            r_bit_cnt <= '0;
            r_state   <= DIV_Y;
          end
        end
        DIV_Y: begin
          r_rem     <= w_rem_nxt;
          r_quo     <= w_quo_nxt;
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == LAST_BIT) r_state <= OUT;
        end
        OUT: begin
          r_cx      <= r_zero ? '0 : r_qx;
          r_cy      <= r_zero ? '0 : r_quo[ADDR_WIDTH-1:0];
          r_count   <= r_cnt_hold;
          r_nopix   <= r_zero;
          r_res_vld <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Entering division overrides the IDLE/SCAN next-state chosen above.
      if (w_go_div) begin
        r_dvs      <= SUM_WIDTH'(w_cnt_nxt);
        r_quo      <= w_sumx_nxt + w_round;
        r_dvd_y    <= w_sumy_nxt + w_round;
        r_rem      <= '0;
        r_bit_cnt  <= '0;
        r_cnt_hold <= w_cnt_nxt;
        r_zero     <= (w_cnt_nxt == '0);
        r_pend     <= 1'b0;
        r_state    <= (w_cnt_nxt == '0) ? OUT : DIV_X;
      end
    end
  end

  assign io_bus.oBUSY    = (r_state != IDLE);
  assign io_bus.oRES_VLD = r_res_vld;
  assign io_bus.oCX      = r_cx;
  assign io_bus.oCY      = r_cy;
  assign io_bus.oCOUNT   = r_count;
  assign io_bus.oNOPIX   = r_nopix;
  assign io_bus.oOVF     = r_ovf;

endmodule

// File: tb/tb_centroid_calc.sv
// Self-checking bench for centroid_calc: directed scenarios plus random frames against a pixel-level model.
// Build with CENTROID_ROUND_EN defined to check the rounding variant.
module tb_centroid_calc;

  localparam int AW      = 11;
  localparam int DW      = 640;
  localparam int SW      = 32;
  localparam int CW      = 20;
  localparam int SUM_W   = 32;
  localparam int N_CHUNK = DW / SW;
`ifdef CENTROID_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic CCLK = 1'b0;
  logic RST  = 1'b1;
  always #5 CCLK = ~CCLK;

  centroid_calc_if #(.ADDR_WIDTH(AW), .MDATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  centroid_calc #(
    .ADDR_WIDTH(AW), .MDATA_WIDTH(DW), .SCAN_W(SW), .CNT_WIDTH(CW), .SUM_WIDTH(SUM_W)
  ) dut (
    .CCLK   (CCLK),
    .RST    (RST),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: whole-frame pixel statistics.
  longint m_cnt, m_sumx, m_sumy;

  function automatic void model_clear();
    m_cnt = 0; m_sumx = 0; m_sumy = 0;
  endfunction

  function automatic void model_add(input logic [AW-1:0] idx, input logic [DW-1:0] d);
    for (int c = 0; c < DW; c++) begin
      if (d[c]) begin
        m_cnt  = m_cnt + 1;
        m_sumx = m_sumx + c;
        m_sumy = m_sumy + longint'(idx);
      end
    end
  endfunction

  function automatic logic [AW-1:0] exp_q(input longint s, input longint c);
    longint d;
    if (c == 0) return '0;
    d = (s + (ROUND ? c / 2 : 0)) & 64'hFFFF_FFFF;
    return AW'(d / c);
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom & $urandom & $urandom;
    if ($urandom_range(0, 4) == 0) d = '0;
    return d;
  endfunction

  function automatic logic [DW-1:0] one_hot(input int col);
    logic [DW-1:0] d;
    d = '0;
    d[col] = 1'b1;
    return d;
  endfunction

  // Stimulus helpers: each is entered and left 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin @(posedge CCLK); #1; end
  endtask

  task automatic pulse_row(input logic [AW-1:0] idx, input logic [DW-1:0] d);
    bus.iROW_VLD = 1'b1; bus.iROW_IDX = idx; bus.iROW_DATA = d;
    step(1);
    bus.iROW_VLD = 1'b0;
  endtask

  task automatic pulse_start();
    bus.iFRAME_START = 1'b1; step(1); bus.iFRAME_START = 1'b0;
  endtask

  task automatic pulse_end();
    bus.iFRAME_END = 1'b1; step(1); bus.iFRAME_END = 1'b0;
  endtask

  // Feeds one row and waits until the scan has finished and the FSM is back in IDLE.
  task automatic feed_row(input logic [AW-1:0] idx, input logic [DW-1:0] d);
    pulse_row(idx, d);
    model_add(idx, d);
    step(N_CHUNK + 1);
  endtask

  // Counts edges until oRES_VLD is seen; edges = 0 means the budget expired.
  task automatic wait_result(input int budget, output int edges);
    edges = 0;
    for (int k = 1; k <= budget; k++) begin
      step(1);
      if (bus.oRES_VLD) begin edges = k; break; end
    end
  endtask

  task automatic check_result(input string name, input int edges);
    logic [AW-1:0] ex, ey;
    ex = exp_q(m_sumx, m_cnt);
    ey = exp_q(m_sumy, m_cnt);
    n_checks++;
    if (edges == 0) begin
      n_errors++; $display("FAIL %s res_vld: no oRES_VLD within budget", name);
    end
    n_checks++;
    if (bus.oCX !== ex) begin
      n_errors++; $display("FAIL %s cx: got %0d expected %0d", name, bus.oCX, ex);
    end
    n_checks++;
    if (bus.oCY !== ey) begin
      n_errors++; $display("FAIL %s cy: got %0d expected %0d", name, bus.oCY, ey);
    end
    n_checks++;
    if (bus.oCOUNT !== CW'(m_cnt)) begin
      n_errors++; $display("FAIL %s count: got %0d expected %0d", name, bus.oCOUNT, m_cnt);
    end
    n_checks++;
    if (bus.oNOPIX !== (m_cnt == 0)) begin
      n_errors++; $display("FAIL %s nopix: got %0b expected %0b", name, bus.oNOPIX, m_cnt == 0);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(3);
    RST = 1'b0;
    n_checks++;
    if ({bus.oBUSY, bus.oRES_VLD, bus.oCX, bus.oCY, bus.oCOUNT, bus.oNOPIX, bus.oOVF} !== '0) begin
      n_errors++;
      $display("FAIL reset outputs: busy=%0b vld=%0b cx=%0d cy=%0d cnt=%0d nopix=%0b ovf=%0b",
               bus.oBUSY, bus.oRES_VLD, bus.oCX, bus.oCY, bus.oCOUNT, bus.oNOPIX, bus.oOVF);
    end
  endtask

  task automatic test_single_pixel();
    int edges;
    pulse_start(); model_clear();
    feed_row(11'd50, one_hot(100));
    pulse_end();
    wait_result(200, edges);
    check_result("single", edges);
    // Edges counted after the one that samples iFRAME_END: total latency 2*SUM_W+2 cycles.
    n_checks++;
    if (edges != 2 * SUM_W + 1) begin
      n_errors++; $display("FAIL single latency: got %0d expected %0d", edges, 2 * SUM_W + 1);
    end
    step(1);
    n_checks++;
    if (bus.oRES_VLD !== 1'b0 || bus.oBUSY !== 1'b0) begin
      n_errors++; $display("FAIL single pulse_width: vld=%0b busy=%0b expected 0 0", bus.oRES_VLD, bus.oBUSY);
    end
  endtask

  task automatic test_pair();
    int edges;
    logic [DW-1:0] d;
    pulse_start(); model_clear();
    d = '0; d[10] = 1'b1; d[11] = 1'b1;
    feed_row(11'd20, d);
    pulse_end();
    wait_result(200, edges);
    check_result("pair", edges);
    n_checks++;
    if (bus.oCX !== (ROUND ? 11'd11 : 11'd10)) begin
      n_errors++; $display("FAIL pair cx_const: got %0d expected %0d", bus.oCX, ROUND ? 11 : 10);
    end
  endtask

  task automatic test_empty();
    int edges;
    pulse_start(); model_clear();
    feed_row(11'd7, '0);
    pulse_end();
    wait_result(200, edges);
    check_result("empty", edges);
    n_checks++;
    if (edges != 1) begin
      n_errors++; $display("FAIL empty latency: got %0d expected 1", edges);
    end
  endtask

  task automatic test_overflow();
    int edges;
    pulse_start(); model_clear();
    pulse_row(11'd0, '1);
    model_add(11'd0, '1);
    step(4);
    pulse_row(11'd1, '1);   // arrives mid-scan, must be dropped
    n_checks++;
    if (bus.oOVF !== 1'b1) begin
      n_errors++; $display("FAIL ovf set: got %0b expected 1", bus.oOVF);
    end
    step(N_CHUNK);
    pulse_end();
    wait_result(200, edges);
    check_result("ovf", edges);
    n_checks++;
    if (bus.oCX !== (ROUND ? 11'd320 : 11'd319) || bus.oCOUNT !== 20'd640 || bus.oOVF !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf frame: cx=%0d cnt=%0d ovf=%0b expected cx=%0d cnt=640 ovf=1",
               bus.oCX, bus.oCOUNT, bus.oOVF, ROUND ? 320 : 319);
    end
    pulse_start();
    n_checks++;
    if (bus.oOVF !== 1'b0) begin
      n_errors++; $display("FAIL ovf clear: got %0b expected 0", bus.oOVF);
    end
  endtask

  task automatic test_pending_end();
    int edges;
    pulse_start(); model_clear();
    pulse_row(11'd479, one_hot(639));
    model_add(11'd479, one_hot(639));
    step(3);
    pulse_end();   // sampled while chunk 3 is being scanned
    wait_result(300, edges);
    check_result("pending", edges);
    n_checks++;
    if (edges != (N_CHUNK - 4) + 2 * SUM_W + 1) begin
      n_errors++;
      $display("FAIL pending latency: got %0d expected %0d", edges, (N_CHUNK - 4) + 2 * SUM_W + 1);
    end
  endtask

  task automatic test_rst_mid_div();
    int edges;
    int pulses;
    pulse_start(); model_clear();
    feed_row(11'd9, one_hot(300));
    pulse_end();
    step(5);
    RST = 1'b1; step(1); RST = 1'b0;
    n_checks++;
    if (bus.oBUSY !== 1'b0 || bus.oRES_VLD !== 1'b0) begin
      n_errors++; $display("FAIL rst busy: busy=%0b vld=%0b expected 0 0", bus.oBUSY, bus.oRES_VLD);
    end
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (bus.oRES_VLD) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++; $display("FAIL rst no_result: got %0d pulses expected 0", pulses);
    end
    model_clear();
    feed_row(11'd5, one_hot(5));
    pulse_end();
    wait_result(200, edges);
    check_result("after_rst", edges);
  endtask

  task automatic test_start_with_row();
    int edges;
    pulse_start(); model_clear();
    feed_row(11'd30, one_hot(200));
    // Frame start and a row on the same cycle: the old frame is discarded, the row starts the new one.
    model_clear();
    bus.iFRAME_START = 1'b1;
    pulse_row(11'd60, one_hot(40));
    bus.iFRAME_START = 1'b0;
    model_add(11'd60, one_hot(40));
    step(N_CHUNK + 1);
    pulse_end();
    wait_result(200, edges);
    check_result("start_row", edges);
  endtask

  task automatic test_random_frames();
    int edges;
    logic [AW-1:0] idx;
    for (int f = 0; f < 12; f++) begin
      pulse_start(); model_clear();
      for (int r = $urandom_range(0, 3); r > 0; r--) begin
        idx = AW'($urandom_range(0, 2047));
        feed_row(idx, rand_row());
      end
      pulse_end();
      wait_result(200, edges);
      check_result($sformatf("random%0d", f), edges);
      step($urandom_range(0, 3));
    end
  endtask

  initial begin
    bus.iFRAME_START = 1'b0;
    bus.iFRAME_END   = 1'b0;
    bus.iROW_VLD     = 1'b0;
    bus.iROW_IDX     = '0;
    bus.iROW_DATA    = '0;
    model_clear();
    step(1);
    test_reset();
    test_single_pixel();
    test_pair();
    test_empty();
    test_overflow();
    test_pending_end();
    test_rst_mid_div();
    test_start_with_row();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
